// File: rtl/gpc_pkg.sv
// Shared constants, types and elaboration helpers for the GPC popcount datapath.
package gpc_pkg;

  localparam int unsigned GPC_IN  = 5;
  localparam int unsigned GPC_OUT = 3;

  localparam string MODE_ONES  = "ONES";
  localparam string MODE_ZEROS = "ZEROS";

  typedef logic [GPC_OUT-1:0] gpc_cnt_t;

  // Ceiling log2; clog2(1) = 0, clog2(31) = 5, clog2(32) = 5.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned p;
    r = 0;
    p = 64'd1;
    for (int i = 0; i < 32; i++) begin
      if (p < 64'(v)) begin
        r = r + 1;
        p = p << 1;
      end
    end
    return r;
  endfunction

  // Number of 5-bit GPC groups needed to cover in_w bits.
  function automatic int unsigned n_groups(input int unsigned in_w);
    return (in_w + GPC_IN - 1) / GPC_IN;
  endfunction

endpackage

// File: rtl/gpc_c5_3.sv
// Combinational 5:3 generalised parallel counter; maps onto one LUT6CY pair.
module gpc_c5_3
  import gpc_pkg::*;
#(
  parameter string USETNM = "USET0",
  parameter string RLOCNM = "X0Y0"
) (
  input  logic [GPC_IN-1:0] in_bits,
  output gpc_cnt_t          cnt_c
);

  // Placement group names feed the attributes on the parent's instances.
  if (USETNM == "" || RLOCNM == "") begin : g_chk_attr
    $error("gpc_c5_3: USETNM and RLOCNM must be non-empty");
  end

  // Count the set bits of the 5-bit group (result 0..5).
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < int'(GPC_IN); i++) begin
      cnt_c = cnt_c + gpc_cnt_t'(in_bits[i]);
    end
  end

endmodule

// File: rtl/gpc_popcount_acc.sv
// Streaming per-frame popcount: input capture, GPC stage, adder-tree stage and
// a saturating frame accumulator, all frozen together under output backpressure.
module gpc_popcount_acc
  import gpc_pkg::*;
#(
  parameter int unsigned IN_W   = 30,
  parameter int unsigned ACC_W  = 16,
  parameter string       MODE   = "ONES",
  parameter string       USETNM = "USET0",
  parameter string       RLOCNM = "X0Y0"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned G      = n_groups(IN_W);
  localparam int unsigned PAD_W  = G * GPC_IN;
  localparam int unsigned SW     = clog2(IN_W + 1);
  localparam bit          INVERT = (MODE == MODE_ZEROS);

  if (IN_W < 1 || IN_W > 240) begin : g_chk_in_w
    $error("gpc_popcount_acc: IN_W must be in 1..240");
  end
  if (ACC_W < SW) begin : g_chk_acc_w
    $error("gpc_popcount_acc: ACC_W must be >= clog2(IN_W+1)");
  end
  if (MODE != MODE_ONES && MODE != MODE_ZEROS) begin : g_chk_mode
    $error("gpc_popcount_acc: MODE must be ONES or ZEROS");
  end

  // Pipeline enable: everything advances unless a held result is refused.
  logic en_c;

  // Input capture stage.
  logic [IN_W-1:0] s0_data_q, s0_data_d;
  logic            s0_valid_q, s0_valid_d;
  logic            s0_last_q, s0_last_d;

  // GPC count stage.
  logic [PAD_W-1:0]      pad_c;
  gpc_cnt_t [G-1:0]      gpc_cnt_c;
  (* U_SET = USETNM, RLOC = RLOCNM *)
  gpc_cnt_t [G-1:0]      s1_cnt_q;
  gpc_cnt_t [G-1:0]      s1_cnt_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_last_q, s1_last_d;

  // Adder-tree stage.
  logic [SW-1:0] sum_c;
  (* U_SET = USETNM, RLOC = RLOCNM *)
  logic [SW-1:0] s2_sum_q;
  logic [SW-1:0] s2_sum_d;
  logic          s2_valid_q, s2_valid_d;
  logic          s2_last_q, s2_last_d;

  // Accumulator and result registers.
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             first_q, first_d;
  logic             sat_f_q, sat_f_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] acc_base_c;
  logic [ACC_W:0]   sum_wide_c;
  logic             clamp_c;
  logic [ACC_W-1:0] sum_sat_c;

  assign en_c      = !out_valid_q || out_ready;
  assign in_ready  = rst_n && en_c;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

  // Optional inversion for ZEROS, then zero padding so pad bits never count.
  always_comb begin
    pad_c = '0;
    pad_c[IN_W-1:0] = INVERT ? ~s0_data_q : s0_data_q;
  end

  for (genvar g = 0; g < int'(G); g++) begin : g_gpc
    (* U_SET = USETNM, RLOC = RLOCNM *)
    gpc_c5_3 #(
      .USETNM (USETNM),
      .RLOCNM (RLOCNM)
    ) u_gpc (
      .in_bits (pad_c[g*GPC_IN +: GPC_IN]),
      .cnt_c   (gpc_cnt_c[g])
    );
  end

  // Sum the group counts; the total never exceeds IN_W so SW bits suffice.
  always_comb begin
    sum_c = '0;
    for (int g = 0; g < int'(G); g++) begin
      sum_c = sum_c + SW'(s1_cnt_q[g]);
    end
  end

  // Next state for the capture, GPC and tree stages.
  always_comb begin
    s0_data_d  = s0_data_q;
    s0_valid_d = s0_valid_q;
    s0_last_d  = s0_last_q;
    s1_cnt_d   = s1_cnt_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s2_sum_d   = s2_sum_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    if (en_c) begin
      s0_data_d  = in_data;
      s0_valid_d = in_valid;
      s0_last_d  = in_valid && in_last;
      s1_cnt_d   = gpc_cnt_c;
      s1_valid_d = s0_valid_q;
      s1_last_d  = s0_last_q;
      s2_sum_d   = sum_c;
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
    end
  end

  // Saturating add of the beat count into the running frame total.
  always_comb begin
    acc_base_c = first_q ? '0 : acc_q;
    sum_wide_c = {1'b0, acc_base_c} + (ACC_W+1)'(s2_sum_q);
    clamp_c    = sum_wide_c[ACC_W];
    sum_sat_c  = clamp_c ? '1 : sum_wide_c[ACC_W-1:0];
  end

  // Accumulator update and result hand-off; a new last result may replace an
  // accepted one on the same edge so frames can stream back to back.
  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    sat_f_d     = sat_f_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    if (en_c) begin
      out_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          out_data_d  = sum_sat_c;
          out_sat_d   = sat_f_q || clamp_c;
          out_valid_d = 1'b1;
          acc_d       = '0;
          sat_f_d     = 1'b0;
          first_d     = 1'b1;
        end else begin
          acc_d       = sum_sat_c;
          sat_f_d     = sat_f_q || clamp_c;
          first_d     = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous reset; a partial frame is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_data_q   <= '0;
      s0_valid_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s1_cnt_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      sat_f_q     <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s0_data_q   <= s0_data_d;
      s0_valid_q  <= s0_valid_d;
      s0_last_q   <= s0_last_d;
      s1_cnt_q    <= s1_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s2_sum_q    <= s2_sum_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      sat_f_q     <= sat_f_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
